// File: rtl/reg_file_param.sv
// Parametrised register file with byte-maskable write, optional zero register and
// write-to-read bypass, plus a per-register pending-write scoreboard for hazard stalls.
module reg_file_param #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  reg_write,
    input  logic [ADDR_W-1:0]     write_reg,
    input  logic [DATA_W-1:0]     write_data,
    input  logic [DATA_W/8-1:0]   write_be,
    input  logic [ADDR_W-1:0]     read_reg1,
    input  logic [ADDR_W-1:0]     read_reg2,
    output logic [DATA_W-1:0]     read_data1,
    output logic [DATA_W-1:0]     read_data2,
    input  logic                  pend_set,
    input  logic [ADDR_W-1:0]     pend_reg,
    input  logic                  flush,
    output logic                  busy1,
    output logic                  busy2
);

    localparam int unsigned DEPTH  = 32'(1) << ADDR_W;
    localparam int unsigned NBYTES = DATA_W / 8;

    logic [DATA_W-1:0] rf_q [DEPTH];
    logic [DATA_W-1:0] rf_d [DEPTH];
    logic [DEPTH-1:0]  pend_q;
    logic [DEPTH-1:0]  pend_d;

    logic              wr_eff;
    logic [DATA_W-1:0] wr_merged;
    logic              hit1;
    logic              hit2;

    // Write qualification and byte merge against the currently stored word.
    always_comb begin : write_merge
        wr_eff    = reg_write && !(ZERO_REG && (write_reg == '0));
        wr_merged = rf_q[write_reg];
        for (int unsigned i = 0; i < NBYTES; i++) begin
            if (write_be[i]) begin
                wr_merged[8*i +: 8] = write_data[8*i +: 8];
            end
        end
    end

    // Later assignments take priority: flush > pend_set > commit > hold.
    always_comb begin : next_state
        for (int unsigned i = 0; i < DEPTH; i++) begin
            rf_d[i] = rf_q[i];
        end
        pend_d = pend_q;
        if (wr_eff) begin
            rf_d[write_reg]   = wr_merged;
            pend_d[write_reg] = 1'b0;
        end
        if (pend_set && !(ZERO_REG && (pend_reg == '0))) begin
            pend_d[pend_reg] = 1'b1;
        end
        if (flush) begin
            pend_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : state_reg
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                rf_q[i] <= '0;
            end
            pend_q <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                rf_q[i] <= rf_d[i];
            end
            pend_q <= pend_d;
        end
    end

    // Read ports; reset forces zero even if a write is being presented.
    always_comb begin : read_ports
        hit1       = BYPASS && wr_eff && (write_reg == read_reg1);
        hit2       = BYPASS && wr_eff && (write_reg == read_reg2);
        read_data1 = hit1 ? wr_merged : rf_q[read_reg1];
        read_data2 = hit2 ? wr_merged : rf_q[read_reg2];
        busy1      = pend_q[read_reg1] && !hit1;
        busy2      = pend_q[read_reg2] && !hit2;
        if (ZERO_REG && (read_reg1 == '0)) begin
            read_data1 = '0;
            busy1      = 1'b0;
        end
        if (ZERO_REG && (read_reg2 == '0)) begin
            read_data2 = '0;
            busy2      = 1'b0;
        end
        if (!rst_n) begin
            read_data1 = '0;
            read_data2 = '0;
            busy1      = 1'b0;
            busy2      = 1'b0;
        end
    end

endmodule

// File: tb/tb_reg_file_param.sv
// Bench for reg_file_param: two configurations (32b/32 regs with zero reg and bypass,
// 64b/16 regs without) driven together and checked against an array-based model.
module tb_reg_file_param;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Instance A: DATA_W=32, ADDR_W=5, ZERO_REG=1, BYPASS=1
    logic        a_reg_write, a_pend_set, a_flush, a_busy1, a_busy2;
    logic [4:0]  a_write_reg, a_read_reg1, a_read_reg2, a_pend_reg;
    logic [31:0] a_write_data, a_read_data1, a_read_data2;
    logic [3:0]  a_write_be;
    // Instance B: DATA_W=64, ADDR_W=4, ZERO_REG=0, BYPASS=0
    logic        b_reg_write, b_pend_set, b_flush, b_busy1, b_busy2;
    logic [3:0]  b_write_reg, b_read_reg1, b_read_reg2, b_pend_reg;
    logic [63:0] b_write_data, b_read_data1, b_read_data2;
    logic [7:0]  b_write_be;

    reg_file_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .reg_write(a_reg_write), .write_reg(a_write_reg),
        .write_data(a_write_data), .write_be(a_write_be), .read_reg1(a_read_reg1),
        .read_reg2(a_read_reg2), .read_data1(a_read_data1), .read_data2(a_read_data2),
        .pend_set(a_pend_set), .pend_reg(a_pend_reg), .flush(a_flush),
        .busy1(a_busy1), .busy2(a_busy2));

    reg_file_param #(.DATA_W(64), .ADDR_W(4), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .reg_write(b_reg_write), .write_reg(b_write_reg),
        .write_data(b_write_data), .write_be(b_write_be), .read_reg1(b_read_reg1),
        .read_reg2(b_read_reg2), .read_data1(b_read_data1), .read_data2(b_read_data2),
        .pend_set(b_pend_set), .pend_reg(b_pend_reg), .flush(b_flush),
        .busy1(b_busy1), .busy2(b_busy2));

    // Current stimulus (shared by both instances, truncated per configuration)
    logic        s_we, s_ps, s_fl;
    logic [4:0]  s_wr, s_r1, s_r2, s_pr;
    logic [63:0] s_wd;
    logic [7:0]  s_be;

    // Reference model: index 0 = instance A, 1 = instance B
    logic [63:0] m_rf   [2][32];
    logic        m_pend [2][32];
    bit          cmp_en = 1'b0;
    int          vectors = 0;
    int          miscompares = 0;

    function automatic bit zr(int d); return d == 0; endfunction
    function automatic bit bp(int d); return d == 0; endfunction

    function automatic logic [4:0] ad(int d, logic [4:0] x);
        return (d == 0) ? x : {1'b0, x[3:0]};
    endfunction

    function automatic bit eff(int d);
        return s_we && !(zr(d) && ad(d, s_wr) == 5'd0);
    endfunction

    function automatic logic [63:0] merged(int d);
        logic [63:0] v  = m_rf[d][ad(d, s_wr)];
        logic [63:0] wd = (d == 0) ? {32'h0, s_wd[31:0]} : s_wd;
        logic [7:0]  be = (d == 0) ? {4'h0, s_be[3:0]} : s_be;
        for (int i = 0; i < 8; i++)
            if (be[i]) v[8*i +: 8] = wd[8*i +: 8];
        return v;
    endfunction

    function automatic logic [63:0] exp_rd(int d, logic [4:0] r);
        logic [4:0] a = ad(d, r);
        if (zr(d) && a == 5'd0) return 64'h0;
        if (bp(d) && eff(d) && ad(d, s_wr) == a) return merged(d);
        return m_rf[d][a];
    endfunction

    function automatic logic exp_busy(int d, logic [4:0] r);
        logic [4:0] a = ad(d, r);
        if (zr(d) && a == 5'd0) return 1'b0;
        if (bp(d) && eff(d) && ad(d, s_wr) == a) return 1'b0;
        return m_pend[d][a];
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++)
            for (int r = 0; r < 32; r++) begin
                m_rf[d][r]   = 64'h0;
                m_pend[d][r] = 1'b0;
            end
    endtask

    task automatic model_update();
        for (int d = 0; d < 2; d++) begin
            logic [4:0]  wa = ad(d, s_wr);
            logic [4:0]  pa = ad(d, s_pr);
            bit          e  = eff(d);
            logic [63:0] mv = merged(d);
            for (int r = 0; r < 32; r++) begin
                if (s_fl) m_pend[d][r] = 1'b0;
                else if (s_ps && pa == 5'(r) && !(zr(d) && r == 0)) m_pend[d][r] = 1'b1;
                else if (e && wa == 5'(r)) m_pend[d][r] = 1'b0;
            end
            if (e) m_rf[d][wa] = mv;
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s t=%0t got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] wr, input logic [63:0] wd,
                         input logic [7:0] be, input logic [4:0] r1, input logic [4:0] r2,
                         input logic ps, input logic [4:0] pr, input logic fl);
        s_we = we; s_wr = wr; s_wd = wd; s_be = be;
        s_r1 = r1; s_r2 = r2; s_ps = ps; s_pr = pr; s_fl = fl;
        a_reg_write = we; a_write_reg = wr; a_write_data = wd[31:0]; a_write_be = be[3:0];
        a_read_reg1 = r1; a_read_reg2 = r2; a_pend_set = ps; a_pend_reg = pr; a_flush = fl;
        b_reg_write = we; b_write_reg = wr[3:0]; b_write_data = wd; b_write_be = be;
        b_read_reg1 = r1[3:0]; b_read_reg2 = r2[3:0]; b_pend_set = ps;
        b_pend_reg = pr[3:0]; b_flush = fl;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle_read(input logic [4:0] r1, input logic [4:0] r2);
        drive(1'b0, 5'd0, 64'h0, 8'h0, r1, r2, 1'b0, 5'd0, 1'b0);
    endtask

    // Every-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("a_rd1",   {32'h0, a_read_data1}, exp_rd(0, s_r1));
            chk("a_rd2",   {32'h0, a_read_data2}, exp_rd(0, s_r2));
            chk("a_busy1", {63'h0, a_busy1},      {63'h0, exp_busy(0, s_r1)});
            chk("a_busy2", {63'h0, a_busy2},      {63'h0, exp_busy(0, s_r2)});
            chk("b_rd1",   b_read_data1,          exp_rd(1, s_r1));
            chk("b_rd2",   b_read_data2,          exp_rd(1, s_r2));
            chk("b_busy1", {63'h0, b_busy1},      {63'h0, exp_busy(1, s_r1)});
            chk("b_busy2", {63'h0, b_busy2},      {63'h0, exp_busy(1, s_r2)});
        end
    end

    initial begin
        rst_n = 1'b0;
        idle_read(5'd3, 5'd0);
        model_reset();
        #1;
        chk("reset_a_rd1",  {32'h0, a_read_data1}, 64'h0);
        chk("reset_b_rd1",  b_read_data1,          64'h0);
        chk("reset_a_busy", {63'h0, a_busy1},      64'h0);
        @(posedge clk);
        #2;
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        // Zero register
        drive(1'b1, 5'd0, 64'hDEADBEEF, 8'hFF, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        cycle();
        drive(1'b0, 5'd0, 64'h0, 8'h0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0);
        #1;
        chk("zero_a_rd",  {32'h0, a_read_data1}, 64'h0);
        chk("zero_b_rd",  b_read_data1,          64'h0000_0000_DEAD_BEEF);
        cycle();
        idle_read(5'd0, 5'd0);
        #1;
        chk("zero_a_busy", {63'h0, a_busy1}, 64'h0);
        chk("zero_b_busy", {63'h0, b_busy1}, 64'h1);
        cycle();

        // Byte enables
        drive(1'b1, 5'd5, 64'h11223344, 8'hFF, 5'd5, 5'd5, 1'b0, 5'd0, 1'b1);
        cycle();
        drive(1'b1, 5'd5, 64'hAABBCCDD, 8'h05, 5'd1, 5'd1, 1'b0, 5'd0, 1'b0);
        cycle();
        idle_read(5'd5, 5'd5);
        #1;
        chk("be_a", {32'h0, a_read_data1}, 64'h11BB33DD);
        chk("be_b", b_read_data2,          64'h11BB33DD);
        cycle();

        // Bypass
        drive(1'b1, 5'd7, 64'h1, 8'hFF, 5'd1, 5'd1, 1'b0, 5'd0, 1'b0);
        cycle();
        drive(1'b1, 5'd7, 64'h55, 8'hFF, 5'd7, 5'd7, 1'b0, 5'd0, 1'b0);
        #1;
        chk("byp_a_rd1",  {32'h0, a_read_data1}, 64'h55);
        chk("byp_a_rd2",  {32'h0, a_read_data2}, 64'h55);
        chk("nobyp_b_rd1", b_read_data1,         64'h1);
        chk("nobyp_b_rd2", b_read_data2,         64'h1);
        cycle();
        idle_read(5'd7, 5'd7);
        #1;
        chk("byp_b_after", b_read_data1, 64'h55);
        cycle();

        // Scoreboard on r9
        drive(1'b0, 5'd0, 64'h0, 8'h0, 5'd9, 5'd9, 1'b1, 5'd9, 1'b0);
        #1;
        chk("sb_a_before", {63'h0, a_busy1}, 64'h0);
        cycle();
        idle_read(5'd9, 5'd9);
        #1;
        chk("sb_a_set", {63'h0, a_busy1}, 64'h1);
        cycle();
        drive(1'b1, 5'd9, 64'h99, 8'hFF, 5'd9, 5'd9, 1'b0, 5'd0, 1'b0);
        #1;
        chk("sb_a_masked", {63'h0, a_busy1}, 64'h0);
        chk("sb_b_unmasked", {63'h0, b_busy1}, 64'h1);
        cycle();
        idle_read(5'd9, 5'd9);
        #1;
        chk("sb_a_commit", {63'h0, a_busy2}, 64'h0);
        chk("sb_b_commit", {63'h0, b_busy2}, 64'h0);
        cycle();
        drive(1'b1, 5'd9, 64'h77, 8'hFF, 5'd1, 5'd1, 1'b1, 5'd9, 1'b0);
        cycle();
        idle_read(5'd9, 5'd9);
        #1;
        chk("sb_a_setwins", {63'h0, a_busy1}, 64'h1);
        chk("sb_b_setwins", {63'h0, b_busy1}, 64'h1);
        cycle();
        drive(1'b0, 5'd0, 64'h0, 8'h0, 5'd9, 5'd9, 1'b1, 5'd9, 1'b1);
        cycle();
        idle_read(5'd9, 5'd9);
        #1;
        chk("sb_a_flush", {63'h0, a_busy1}, 64'h0);
        chk("sb_b_flush", {63'h0, b_busy1}, 64'h0);
        cycle();

        // Random traffic
        for (int n = 0; n < 10000; n++) begin
            logic        we, ps, fl;
            logic [4:0]  wr, r1, r2, pr;
            logic [63:0] wd;
            logic [7:0]  be;
            we = 1'($urandom_range(0, 1));
            wr = 5'($urandom_range(0, 31));
            wd = {$urandom, $urandom};
            be = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            r1 = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
            r2 = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
            ps = ($urandom_range(0, 2) == 0);
            pr = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
            fl = ($urandom_range(0, 31) == 0);
            drive(we, wr, wd, be, r1, r2, ps, pr, fl);
            cycle();
        end

        // Fill, then asynchronous reset mid-cycle
        for (int a = 1; a < 32; a++) begin
            drive(1'b1, 5'(a), {$urandom, $urandom}, 8'hFF, 5'(a), 5'(31 - a),
                  1'b1, 5'(32 - a), 1'b0);
            cycle();
        end
        cmp_en = 1'b0;
        #3;
        rst_n = 1'b0;
        for (int a = 0; a < 32; a++) begin
            drive(1'b1, 5'(a), 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 5'(a), 5'(31 - a),
                  1'b0, 5'd0, 1'b0);
            #1;
            chk("rst_a_rd1",   {32'h0, a_read_data1}, 64'h0);
            chk("rst_a_rd2",   {32'h0, a_read_data2}, 64'h0);
            chk("rst_a_busy",  {62'h0, a_busy1, a_busy2}, 64'h0);
            chk("rst_b_rd1",   b_read_data1, 64'h0);
            chk("rst_b_rd2",   b_read_data2, 64'h0);
            chk("rst_b_busy",  {62'h0, b_busy1, b_busy2}, 64'h0);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        model_reset();
        cmp_en = 1'b1;
        for (int a = 0; a < 32; a++) begin
            idle_read(5'(a), 5'(31 - a));
            cycle();
        end
        cmp_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
